// File: rtl/if_id_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch_if
// Brief    : Instruction-memory req/ack bus between fetch and imem
// Revision : 1.0
// ============================================================================
interface if_id_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_id_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch
// Brief    : Fetch front end + IF/ID register with hold buffer and wrong-path drop
// Revision : 1.0
// ============================================================================
module if_id_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] PCF_i,
    input  wire logic [31:0] PCPlus4F_i,
    input  wire logic        StallD_i,
    input  wire logic        FlushD_i,
    output logic             FetchStallF_o,
    output logic [31:0]      InstrD_o,
    output logic [31:0]      PCPlus4D_o,
    output logic             ValidD_o,
    if_id_fetch_if.master    imem
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q,   buf_pc4_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] pc4_q,       pc4_d;
    logic        valid_q,     valid_d;
    logic        req;
    logic [31:0] addr;
    logic        fetch_stall;
    logic        ack;

    assign ack = imem.imem_ack;

    always_comb begin
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        req         = 1'b0;
        addr        = PCF_i;
        fetch_stall = 1'b0;

        // Flush always bubbles IF/ID; PC+4 is left as-is
        if (FlushD_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (FlushD_i) begin
                    if (!ack) begin
                        drop_addr_d = PCF_i;
                        state_d     = DROP;
                    end
                end else if (ack) begin
                    if (!StallD_i) begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = PCPlus4F_i;
                        valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc4_d   = PCPlus4F_i;
                        state_d     = HOLD;
                        fetch_stall = 1'b1;
                    end
                end else begin
                    fetch_stall = 1'b1;
                    if (!StallD_i) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
            end
            DROP: begin
                // Stale request must run to completion; memory cannot retarget it
                req         = 1'b1;
                addr        = drop_addr_q;
                fetch_stall = !FlushD_i;
                if (ack) begin
                    state_d = FETCH;
                end
                if (!StallD_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (FlushD_i) begin
                    state_d = FETCH;
                end else if (!StallD_i) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end else begin
                    fetch_stall = 1'b1;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (reset) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            drop_addr_q <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign FetchStallF_o  = fetch_stall;
    assign InstrD_o       = instr_q;
    assign PCPlus4D_o     = pc4_q;
    assign ValidD_o       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_fetch
// Brief    : Directed vector table plus randomized run against a reference model
// Revision : 1.0
// ============================================================================
module tb_if_id_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcf, pcp4;
    logic        stall, flush;
    logic        fstall;
    logic [31:0] instr, pc4;
    logic        valid;

    always #5 clk = ~clk;

    if_id_fetch_if bus();

    if_id_fetch #(.NOP_INSTR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCF_i         (pcf),
        .PCPlus4F_i    (pcp4),
        .StallD_i      (stall),
        .FlushD_i      (flush),
        .FetchStallF_o (fstall),
        .InstrD_o      (instr),
        .PCPlus4D_o    (pc4),
        .ValidD_o      (valid),
        .imem          (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic [31:0] pcf;
        logic        st, fl, ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fs;
        logic [31:0] e_instr, e_pc4;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [31:0] p, input logic s,
                                input logic f, input logic a, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic efs,
                                input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        vec_t v;
        v.rst = r; v.pcf = p; v.st = s; v.fl = f; v.ack = a; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_fs = efs;
        v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] p, input logic s, input logic f,
                         input logic a, input logic [31:0] d);
        reset = r; pcf = p; pcp4 = p + 32'd4; stall = s; flush = f;
        bus.imem_ack = a; bus.imem_rdata = d;
    endtask

    // Reference model state
    logic [31:0] mi, mp, pc, stale_addr, rd;
    logic        mv, stale, r, st, fl, m_req, m_fs, m_ack;
    logic [31:0] m_addr;
    ent_t        held[$];
    int          mcnt, mlat;

    initial begin
        // rst, pcf, st, fl, ack, rdata | req, addr, fstall | instr, pc4, valid
        tbl.push_back(mk(0, 32'h3000, 0, 0, 1, 32'h20080001, 1, 32'h3000, 0, 32'h20080001, 32'h3004, 1));
        tbl.push_back(mk(0, 32'h3004, 0, 0, 1, 32'h20080002, 1, 32'h3004, 0, 32'h20080002, 32'h3008, 1));
        tbl.push_back(mk(0, 32'h3008, 0, 0, 1, 32'h20080003, 1, 32'h3008, 0, 32'h20080003, 32'h300C, 1));
        tbl.push_back(mk(0, 32'h300C, 0, 0, 1, 32'h20080004, 1, 32'h300C, 0, 32'h20080004, 32'h3010, 1));
        // latency 2 at 0x3000
        tbl.push_back(mk(0, 32'h3000, 0, 0, 0, 32'hxxxxxxxx, 1, 32'h3000, 1, 32'h0, 32'h3010, 0));
        tbl.push_back(mk(0, 32'h3000, 0, 0, 0, 32'hxxxxxxxx, 1, 32'h3000, 1, 32'h0, 32'h3010, 0));
        tbl.push_back(mk(0, 32'h3000, 0, 0, 1, 32'h20080001, 1, 32'h3000, 0, 32'h20080001, 32'h3004, 1));
        // decode stall with ack at 0x3004, released after 3 cycles
        tbl.push_back(mk(0, 32'h3004, 1, 0, 1, 32'h20080002, 1, 32'h3004, 1, 32'h20080001, 32'h3004, 1));
        tbl.push_back(mk(0, 32'h3004, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h20080001, 32'h3004, 1));
        tbl.push_back(mk(0, 32'h3004, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h20080001, 32'h3004, 1));
        tbl.push_back(mk(0, 32'h3004, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h20080002, 32'h3008, 1));
        // flush while request at 0x3008 is pending, redirect to 0x3040
        tbl.push_back(mk(0, 32'h3008, 0, 0, 0, 32'h0, 1, 32'h3008, 1, 32'h0, 32'h3008, 0));
        tbl.push_back(mk(0, 32'h3008, 0, 1, 0, 32'h0, 1, 32'h3008, 0, 32'h0, 32'h3008, 0));
        tbl.push_back(mk(0, 32'h3040, 0, 0, 0, 32'h0, 1, 32'h3008, 1, 32'h0, 32'h3008, 0));
        tbl.push_back(mk(0, 32'h3040, 0, 0, 1, 32'hDEADBEEF, 1, 32'h3008, 1, 32'h0, 32'h3008, 0));
        tbl.push_back(mk(0, 32'h3040, 0, 0, 1, 32'h8C010040, 1, 32'h3040, 0, 32'h8C010040, 32'h3044, 1));
        // flush coincident with ack at 0x300C
        tbl.push_back(mk(0, 32'h300C, 0, 1, 1, 32'h20080004, 1, 32'h300C, 0, 32'h0, 32'h3044, 0));
        // enter DROP, then reset
        tbl.push_back(mk(0, 32'h3010, 0, 1, 0, 32'h0, 1, 32'h3010, 0, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(0, 32'h3050, 0, 0, 0, 32'h0, 1, 32'h3010, 1, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(1, 32'h3050, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 32'h3000, 0, 0, 1, 32'h20080001, 1, 32'h3000, 0, 32'h20080001, 32'h3004, 1));
        // flush while holding a buffered instruction
        tbl.push_back(mk(0, 32'h3004, 1, 0, 1, 32'h20080002, 1, 32'h3004, 1, 32'h20080001, 32'h3004, 1));
        tbl.push_back(mk(0, 32'h3004, 1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h3004, 0));
        tbl.push_back(mk(0, 32'h3040, 0, 0, 1, 32'h8C010040, 1, 32'h3040, 0, 32'h8C010040, 32'h3044, 1));
        // second redirect while in DROP keeps the stale address
        tbl.push_back(mk(0, 32'h3048, 0, 1, 0, 32'h0, 1, 32'h3048, 0, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(0, 32'h3080, 1, 1, 0, 32'h0, 1, 32'h3048, 0, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(0, 32'h3090, 1, 0, 0, 32'h0, 1, 32'h3048, 1, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(0, 32'h3090, 0, 0, 1, 32'h55555555, 1, 32'h3048, 1, 32'h0, 32'h3044, 0));
        tbl.push_back(mk(0, 32'h3090, 0, 0, 1, 32'h11112222, 1, 32'h3090, 0, 32'h11112222, 32'h3094, 1));

        // Reset state
        apply(1, 32'h3000, 0, 0, 0, 32'h0);
        #2;
        chk("rst_req", bus.imem_req, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_valid", valid, 1'b0);

        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].pcf, tbl[k].st, tbl[k].fl, tbl[k].ack, tbl[k].rdata);
            #2;
            chk($sformatf("v%0d_req", k), bus.imem_req, tbl[k].e_req);
            if (tbl[k].e_req) chk($sformatf("v%0d_addr", k), bus.imem_addr, tbl[k].e_addr);
            if (!tbl[k].rst)  chk($sformatf("v%0d_fstall", k), fstall, tbl[k].e_fs);
            @(posedge clk); #1;
            chk($sformatf("v%0d_instr", k), instr, tbl[k].e_instr);
            chk($sformatf("v%0d_pc4", k), pc4, tbl[k].e_pc4);
            chk($sformatf("v%0d_valid", k), valid, tbl[k].e_valid);
        end

        // Randomized run: bench acts as PC register, hazard unit and variable-latency memory
        pc = 32'h3000; mi = 32'h0; mp = 32'h0; mv = 1'b0;
        stale = 1'b0; stale_addr = 32'h0; held.delete();
        mcnt = 0; mlat = int'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            m_fs = 1'b0; m_addr = pc;
            if (r) begin
                m_req = 1'b0;
            end else if (held.size() != 0) begin
                m_req = 1'b0;
                m_fs  = !(fl || !st);
            end else if (stale) begin
                m_req  = 1'b1;
                m_addr = stale_addr;
                m_fs   = !fl;
            end else begin
                m_req = 1'b1;
            end
            m_ack = m_req && (mcnt == mlat);
            rd    = m_ack ? mem_word(m_addr) : $urandom();
            if (!r && held.size() == 0 && !stale) m_fs = !(fl || (m_ack && !st));

            apply(r, pc, st, fl, m_ack, rd);
            #2;
            chk("rnd_req", bus.imem_req, m_req);
            if (m_req) chk("rnd_addr", bus.imem_addr, m_addr);
            if (!r)    chk("rnd_fstall", fstall, m_fs);
            @(posedge clk); #1;

            if (r) begin
                mi = 32'h0; mp = 32'h0; mv = 1'b0; held.delete(); stale = 1'b0;
            end else if (held.size() != 0) begin
                if (fl) begin
                    held.delete(); mi = 32'h0; mv = 1'b0;
                end else if (!st) begin
                    mi = held[0].i; mp = held[0].p; mv = 1'b1; held.delete();
                end
            end else if (stale) begin
                if (m_ack) stale = 1'b0;
                if (fl || !st) begin mi = 32'h0; mv = 1'b0; end
            end else begin
                if (fl) begin
                    mi = 32'h0; mv = 1'b0;
                    if (!m_ack) begin stale = 1'b1; stale_addr = pc; end
                end else if (m_ack) begin
                    if (!st) begin mi = rd; mp = pc + 32'd4; mv = 1'b1; end
                    else held.push_back('{i: rd, p: pc + 32'd4});
                end else if (!st) begin
                    mi = 32'h0; mv = 1'b0;
                end
            end

            if (r || !m_req) mcnt = 0;
            else if (m_ack) begin mcnt = 0; mlat = int'($urandom_range(0, 3)); end
            else mcnt++;

            if (r)                 pc = 32'h3000;
            else if (fl)           pc = $urandom() & 32'h0000_FFFC;
            else if (!m_fs && !st) pc = pc + 32'd4;

            chk("rnd_instr", instr, mi);
            chk("rnd_pc4", pc4, mp);
            chk("rnd_valid", valid, mv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
